// File: rtl/ps2_key_decoder_pkg.sv
// Shared codes, state encodings and event tuple for the PS/2 key decoder.
// Prefix bytes, modifier/lock scan codes and the PAUSE skip length live here.
package ps2_key_decoder_pkg;

  localparam logic [7:0] PFX_E0    = 8'hE0;
  localparam logic [7:0] PFX_F0    = 8'hF0;
  localparam logic [7:0] PFX_E1    = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_INS    = 8'h70;
  localparam logic [2:0] PAUSE_LEN = 3'd7;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_E0    = 3'd1,
    P_BRK   = 3'd2,
    P_E0BRK = 3'd3,
    P_PAUSE = 3'd4
  } parse_state_t;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_HIGH = 2'd1,
    E_GAP  = 2'd2
  } emit_state_t;

  typedef struct packed {
    logic [7:0] scan;
    logic [7:0] scan_e0;
    logic [7:0] ascii;
    logic       is_ascii;
  } key_evt_t;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic lalt;
    logic ralt;
    logic caps_held;
    logic ins_held;
    logic caps;
    logic ins;
  } mod_state_t;

  // Modifier and lock makes update state only; they never produce a key event.
  function automatic logic is_mod_key(input logic [7:0] code, input logic e0);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT) || (code == SC_CTRL) ||
           (code == SC_ALT) || (code == SC_CAPS) || (e0 && code == SC_INS);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-stream input and KBHandler output bundle of the PS/2 key decoder.
interface ps2_key_decoder_if;
  import ps2_key_decoder_pkg::*;

  // ps2_valid is a one-cycle strobe qualifying ps2_byte, no backpressure;
  // newKey is a level pulse whose rising edge marks one new key event.
  logic [7:0]   ps2_byte;
  logic         ps2_valid;
  logic [7:0]   scanCode;
  logic [7:0]   scanCode_E0;
  logic         shift;
  logic         ctrl;
  logic         alt;
  logic         capslock;
  logic         insert;
  logic         newKey;
  logic [7:0]   ASCII;
  logic         isASCIIkey;
  parse_state_t dbg_parse;
  emit_state_t  dbg_emit;

  modport master (
    output ps2_byte, ps2_valid,
    input  scanCode, scanCode_E0, shift, ctrl, alt, capslock, insert,
           newKey, ASCII, isASCIIkey, dbg_parse, dbg_emit
  );

  modport slave (
    input  ps2_byte, ps2_valid,
    output scanCode, scanCode_E0, shift, ctrl, alt, capslock, insert,
           newKey, ASCII, isASCIIkey, dbg_parse, dbg_emit
  );

endinterface

// File: rtl/ps2_key_decoder_scan_to_ascii.sv
// US-layout scan code set 2 to ASCII lookup; E0 codes and non-printing keys give 0.
module ps2_key_decoder_scan_to_ascii (
  input  logic [7:0] code,
  input  logic       e0,
  input  logic       shift,
  input  logic       capslock,
  output logic [7:0] ascii
);

  logic [7:0] base;
  logic [7:0] shifted;
  logic       letter;

  always_comb begin
    base    = 8'h00;
    shifted = 8'h00;
    case (code)
      8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";
      8'h23: base = "d";  8'h24: base = "e";  8'h2B: base = "f";
      8'h34: base = "g";  8'h33: base = "h";  8'h43: base = "i";
      8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
      8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";
      8'h4D: base = "p";  8'h15: base = "q";  8'h2D: base = "r";
      8'h1B: base = "s";  8'h2C: base = "t";  8'h3C: base = "u";
      8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
      8'h35: base = "y";  8'h1A: base = "z";
      8'h16: begin base = "1";  shifted = "!";  end
      8'h1E: begin base = "2";  shifted = "@";  end
      8'h26: begin base = "3";  shifted = "#";  end
      8'h25: begin base = "4";  shifted = "$";  end
      8'h2E: begin base = "5";  shifted = "%";  end
      8'h36: begin base = "6";  shifted = "^";  end
      8'h3D: begin base = "7";  shifted = "&";  end
      8'h3E: begin base = "8";  shifted = "*";  end
      8'h46: begin base = "9";  shifted = "(";  end
      8'h45: begin base = "0";  shifted = ")";  end
      8'h0E: begin base = 8'h60; shifted = "~";  end
      8'h4E: begin base = "-";  shifted = "_";  end
      8'h55: begin base = "=";  shifted = "+";  end
      8'h54: begin base = "[";  shifted = "{";  end
      8'h5B: begin base = "]";  shifted = "}";  end
      8'h5D: begin base = "\\"; shifted = "|";  end
      8'h4C: begin base = ";";  shifted = ":";  end
      8'h52: begin base = "'";  shifted = "\""; end
      8'h41: begin base = ",";  shifted = "<";  end
      8'h49: begin base = ".";  shifted = ">";  end
      8'h4A: begin base = "/";  shifted = "?";  end
      8'h29: begin base = " ";  shifted = " ";  end
      default: begin base = 8'h00; shifted = 8'h00; end
    endcase
  end

  // Capslock only affects letters; the shifted punctuation set follows shift alone.
  assign letter = (base >= 8'h61) && (base <= 8'h7A);

  always_comb begin
    ascii = 8'h00;
    if (e0)          ascii = 8'h00;
    else if (letter) ascii = (shift ^ capslock) ? (base - 8'h20) : base;
    else             ascii = shift ? shifted : base;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 byte stream to KBHandler bundle: prefix parser, modifier/lock tracking and
// a newKey pulse shaper with a one-entry latest-wins pending slot.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int NEWKEY_HOLD = 4,
  parameter int NEWKEY_GAP  = 4
) (
  input logic             clk,
  input logic             rst,
  ps2_key_decoder_if.slave kb
);

  parse_state_t parse_q, parse_d;
  logic [2:0]   skip_q, skip_d;
  mod_state_t   mod_q, mod_d;
  emit_state_t  emit_q, emit_d;
  logic [7:0]   ecnt_q, ecnt_d;
  key_evt_t     out_q, out_d;
  key_evt_t     pend_q, pend_d;
  logic         pend_v_q, pend_v_d;

  logic       make_v, brk_v, ev_e0, ev_new, launch;
  logic       shift_now, ctrl_now, alt_now;
  logic [7:0] rx, ascii_w;
  key_evt_t   new_evt;

  assign rx        = kb.ps2_byte;
  assign shift_now = mod_q.lshift | mod_q.rshift;
  assign ctrl_now  = mod_q.lctrl | mod_q.rctrl;
  assign alt_now   = mod_q.lalt | mod_q.ralt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parse_q  <= P_IDLE;
      skip_q   <= 3'd0;
      mod_q    <= '0;
      emit_q   <= E_IDLE;
      ecnt_q   <= 8'd0;
      out_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      parse_q  <= parse_d;
      skip_q   <= skip_d;
      mod_q    <= mod_d;
      emit_q   <= emit_d;
      ecnt_q   <= ecnt_d;
      out_q    <= out_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  // A prefix seen mid-sequence restarts parsing as though it arrived in IDLE.
  always_comb begin
    parse_d = parse_q;
    skip_d  = skip_q;
    make_v  = 1'b0;
    brk_v   = 1'b0;
    ev_e0   = 1'b0;
    if (kb.ps2_valid) begin
      if (parse_q == P_PAUSE) begin
        skip_d = skip_q - 3'd1;
        if (skip_q <= 3'd1) parse_d = P_IDLE;
      end else if (rx == PFX_E0) begin
        parse_d = P_E0;
      end else if (rx == PFX_F0) begin
        parse_d = (parse_q == P_E0) ? P_E0BRK : P_BRK;
      end else if (rx == PFX_E1) begin
        parse_d = P_PAUSE;
        skip_d  = PAUSE_LEN;
      end else begin
        parse_d = P_IDLE;
        make_v  = (parse_q == P_IDLE) || (parse_q == P_E0);
        brk_v   = (parse_q == P_BRK) || (parse_q == P_E0BRK);
        ev_e0   = (parse_q == P_E0) || (parse_q == P_E0BRK);
      end
    end
  end

  // Held bits block lock re-toggling on typematic repeats until the break.
  always_comb begin
    mod_d = mod_q;
    if (make_v || brk_v) begin
      if (!ev_e0 && rx == SC_LSHIFT) mod_d.lshift = make_v;
      if (!ev_e0 && rx == SC_RSHIFT) mod_d.rshift = make_v;
      if (rx == SC_CTRL) begin
        if (ev_e0) mod_d.rctrl = make_v;
        else       mod_d.lctrl = make_v;
      end
      if (rx == SC_ALT) begin
        if (ev_e0) mod_d.ralt = make_v;
        else       mod_d.lalt = make_v;
      end
      if (!ev_e0 && rx == SC_CAPS) begin
        if (make_v && !mod_q.caps_held) mod_d.caps = ~mod_q.caps;
        mod_d.caps_held = make_v;
      end
      if (ev_e0 && rx == SC_INS) begin
        if (make_v && !mod_q.ins_held) mod_d.ins = ~mod_q.ins;
        mod_d.ins_held = make_v;
      end
    end
  end

  ps2_key_decoder_scan_to_ascii u_scan_to_ascii (
    .code     (rx),
    .e0       (ev_e0),
    .shift    (shift_now),
    .capslock (mod_q.caps),
    .ascii    (ascii_w)
  );

  always_comb begin
    ev_new           = make_v && !is_mod_key(rx, ev_e0);
    new_evt.scan     = ev_e0 ? 8'h00 : rx;
    new_evt.scan_e0  = ev_e0 ? rx : 8'h00;
    new_evt.ascii    = ascii_w;
    new_evt.is_ascii = (ascii_w >= 8'h20) && (ascii_w <= 8'h7E) && !ctrl_now && !alt_now;
  end

  // A fresh event always beats the pending slot, both when launching and when parking.
  always_comb begin
    emit_d   = emit_q;
    ecnt_d   = ecnt_q;
    out_d    = out_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    launch   = 1'b0;
    case (emit_q)
      E_IDLE: launch = ev_new || pend_v_q;
      E_HIGH: begin
        if (ecnt_q == 8'd0) begin
          emit_d = E_GAP;
          ecnt_d = 8'(NEWKEY_GAP - 1);
        end else begin
          ecnt_d = ecnt_q - 8'd1;
        end
      end
      E_GAP: begin
        if (ecnt_q != 8'd0)          ecnt_d = ecnt_q - 8'd1;
        else if (ev_new || pend_v_q) launch = 1'b1;
        else                         emit_d = E_IDLE;
      end
      default: emit_d = E_IDLE;
    endcase
    if (launch) begin
      emit_d   = E_HIGH;
      ecnt_d   = 8'(NEWKEY_HOLD - 1);
      out_d    = ev_new ? new_evt : pend_q;
      pend_v_d = 1'b0;
    end else if (ev_new) begin
      pend_d   = new_evt;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    kb.scanCode    = out_q.scan;
    kb.scanCode_E0 = out_q.scan_e0;
    kb.ASCII       = out_q.ascii;
    kb.isASCIIkey  = out_q.is_ascii;
    kb.newKey      = (emit_q == E_HIGH);
    kb.shift       = shift_now;
    kb.ctrl        = ctrl_now;
    kb.alt         = alt_now;
    kb.capslock    = mod_q.caps;
    kb.insert      = mod_q.ins;
    kb.dbg_parse   = parse_q;
    kb.dbg_emit    = emit_q;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream stage of the bash video memory: converts the raw PS/2 byte stream from the PS/2 receiver into the KBHandler signal bundle.
- Bundle: scanCode, scanCode_E0, shift, ctrl, alt, capslock, insert, newKey, ASCII, isASCIIkey.
- Resolves E0/F0/E1 prefixes, tracks modifier and lock state, maps make codes to US-layout ASCII.
- Shapes newKey so the consumer's 3-flop rising-edge detector sees exactly one edge per key event.

Parameters:
- NEWKEY_HOLD, 4, cycles newKey stays high per event (min 2).
- NEWKEY_GAP, 4, minimum low cycles between two newKey pulses (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- ps2_byte  in  8  received PS/2 byte, valid only when ps2_valid=1.
- ps2_valid  in  1  one-cycle strobe per received byte.
- scanCode  out  8  non-prefixed make code of the last event; 0 when that event was E0-prefixed.
- scanCode_E0  out  8  E0-prefixed make code of the last event; 0 when that event was not E0-prefixed.
- shift, ctrl, alt  out  1 each  live modifier levels (left OR right).
- capslock, insert  out  1 each  toggle states.
- newKey  out  1  event pulse, high NEWKEY_HOLD cycles.
- ASCII  out  8  character for the last event; 0 if none.
- isASCIIkey  out  1  1 when ASCII is a printable character to insert.

Behaviour:
- Reset: all outputs 0, parser in IDLE, emitter in E_IDLE, pending cleared, held-flags cleared.
- Parser FSM, advances only on ps2_valid:
  - IDLE: E0 -> E0; F0 -> BRK; E1 -> PAUSE (skip cnt=7); other -> make(code, e0=0).
  - E0: F0 -> E0BRK; other -> make(code, e0=1), back to IDLE.
  - BRK: break(code, e0=0) -> IDLE.
  - E0BRK: break(code, e0=1) -> IDLE.
  - PAUSE: swallow bytes and decrement; at 0 -> IDLE. No outputs change.
  - Unexpected prefix in E0/BRK/E0BRK (E0, F0 or E1): restart as if seen in IDLE.
- Modifiers, updated the cycle after the final byte, independent of the emitter:
  - shift: 12/59, e0=0 only. E0 12 and E0 59 (print-screen fake shift) are ignored.
  - ctrl: 14, either e0. alt: 11, either e0.
  - Make sets the held bit, break clears it; output = OR of left/right held bits.
- Locks:
  - capslock toggles on make 58 only when caps_held=0; caps_held is set on make and cleared on break 58.
  - insert toggles the same way on E0 70. Typematic repeats therefore never re-toggle.
- Event generation:
  - Every make that is not a modifier or lock key (12, 59, 14, 11, 58, E0 70) creates an event, including typematic repeats.
  - Event tuple is latched at creation with the modifiers as of that byte:
    - scanCode = e0 ? 0 : code; scanCode_E0 = e0 ? code : 0.
    - ASCII from scan_to_ascii.
    - isASCIIkey = (ASCII in 20..7E) && !ctrl && !alt.
  - Breaks never create events.
- ASCII mapping (scan_to_ascii):
  - Letters: uppercase iff shift XOR capslock.
  - Digits/punctuation: shifted set iff shift (capslock ignored).
  - Space 29 -> 20.
  - Enter, backspace, tab, esc, F-keys, keypad, and all E0 codes -> ASCII 0, isASCIIkey 0.
- Emitter FSM:
  - E_IDLE: on event, drive the tuple, newKey=1, go to E_HIGH.
  - E_HIGH: NEWKEY_HOLD cycles, then newKey=0, go to E_GAP.
  - E_GAP: NEWKEY_GAP cycles, then E_IDLE, or straight to E_HIGH if pending is valid.
  - Tuple outputs change only on entry to E_HIGH and stay stable until the next entry.
  - Event arriving outside E_IDLE goes into the one-entry pending register; a later event overwrites it (latest wins).
- Latency: last byte strobe at cycle t -> tuple valid and newKey=1 at t+1 when the emitter is idle.
- Simultaneous: an event and pending drain in the same cycle -> the new event overwrites pending.
- rst mid-sequence (e.g. after E0, or during PAUSE) -> IDLE; the partial sequence is discarded.

Decomposition:
- Shared header ps2_codes.vh: prefix constants (E0, F0, E1), modifier/lock codes, parser and emitter state encodings, PAUSE_LEN=7.
- One sub-module: scan_to_ascii (combinational; inputs code, e0, shift, capslock; outputs ascii). Holds the full US table.
- Parser, modifier tracking and emitter stay in ps2_key_decoder.

Test Plan:
- Byte 1C -> next cycle scanCode=1C, scanCode_E0=00, ASCII=61, isASCIIkey=1, newKey high exactly 4 cycles; then F0 1C -> no newKey.
- 12, 1C, F0 1C, F0 12 -> ASCII=41, shift=1 during the event, shift=0 after F0 12; repeat with capslock on plus shift -> ASCII=61.
- 58, 58, 58, F0 58 -> capslock=1 after the first byte only; 58, F0 58 again -> capslock=0. E0 70 likewise toggles insert once.
- E0 5A -> scanCode=00, scanCode_E0=5A, ASCII=00, isASCIIkey=0; 66 -> scanCode=66, isASCIIkey=0; E0 12 -> shift stays 0, no event.
- E1 14 77 E1 F0 14 F0 77, then 16 -> only one event (scanCode=16, ASCII=31); ctrl stays 0 throughout.
- Makes 1C, 32, 21 strobed 1 cycle apart -> two newKey pulses (1C, then 21), each separated by >=4 low cycles; rst asserted mid-pulse -> all outputs 0 immediately.
